// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - Registered MIPS decode stage with a flow-controlled record FIFO
//
// Purpose: splits each fetched instruction into fields, classifies it and computes
// the extended immediate and jump target, then buffers the decoded record in a
// DEPTH-entry FIFO with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush               synchronous discard of all buffered records
//   in_valid/in_ready   fetch-side handshake; in_instr, in_pc carry the instruction
//   out_valid/out_ready register-read-side handshake for the head record
//   out_op..out_func    raw instruction fields of the head record
//   out_imm_ext         extended immediate (XLEN)
//   out_jtarget         J-type target (XLEN)
//   out_class           instruction class (0..6)
//   out_pc              PC of the head record
//   count               occupied entries
module instr_decode_stage #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [5:0]       out_op,
   output logic [4:0]       out_rs,
   output logic [4:0]       out_rt,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_shamt,
   output logic [5:0]       out_func,
   output logic [XLEN-1:0]  out_imm_ext,
   output logic [XLEN-1:0]  out_jtarget,
   output logic [2:0]       out_class,
   output logic [XLEN-1:0]  out_pc,
   output logic [CNT_W-1:0] count
);
   // A one-entry buffer still needs a 1-bit pointer; it simply never leaves 0.
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] imm_ext;
      logic [XLEN-1:0] jtarget;
      logic [2:0]      cls;
      logic [XLEN-1:0] pc;
   } rec_t;

   rec_t             mem [DEPTH];
   rec_t             in_rec;
   rec_t             head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [5:0]       op;
   logic [15:0]      imm16;
   logic [XLEN-1:0]  pc_plus4;
   logic             push;
   logic             pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Input-side decode: the record is fully formed before it enters the FIFO.
   always_comb begin
      op       = in_instr[31:26];
      imm16    = in_instr[15:0];
      pc_plus4 = in_pc + XLEN'(4);

      in_rec.instr   = in_instr;
      in_rec.pc      = in_pc;
      in_rec.jtarget = {pc_plus4[XLEN-1:28], in_instr[25:0], 2'b00};

      casez (op)
         6'b000000:            in_rec.cls = 3'd0;
         6'b001???:            in_rec.cls = 3'd1;
         6'b100???:            in_rec.cls = 3'd2;
         6'b101???:            in_rec.cls = 3'd3;
         6'b000001, 6'b0001??: in_rec.cls = 3'd4;
         6'b00001?:            in_rec.cls = 3'd5;
         default:              in_rec.cls = 3'd6;
      endcase

      // Logical immediates zero-extend; lui is a 32-bit value sign-extended to XLEN.
      case (op)
         6'b001100, 6'b001101, 6'b001110: in_rec.imm_ext = XLEN'(imm16);
         6'b001111: in_rec.imm_ext = XLEN'($signed({imm16, 16'h0000}));
         default:   in_rec.imm_ext = XLEN'($signed(imm16));
      endcase
   end

   assign out_valid = (count != '0);
   assign in_ready  = !flush && ((count < CNT_FULL) || out_ready);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         // A head dequeued in this cycle is consumed; everything else is dropped.
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only observable once count covers it.
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= in_rec;
   end

   assign head = out_valid ? mem[rd_ptr] : '0;

   assign out_op      = head.instr[31:26];
   assign out_rs      = head.instr[25:21];
   assign out_rt      = head.instr[20:16];
   assign out_rd      = head.instr[15:11];
   assign out_shamt   = head.instr[10:6];
   assign out_func    = head.instr[5:0];
   assign out_imm_ext = head.imm_ext;
   assign out_jtarget = head.jtarget;
   assign out_class   = head.cls;
   assign out_pc      = head.pc;
endmodule
